// File: rtl/cpu_output_capture.sv
// Change-triggered capture of the CPU output bus into a timestamped, drainable FIFO.
// Define CPU_CAPTURE_ALL_EN to record every enabled cycle instead of only value changes.
module cpu_output_capture #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          cpu_data,
    input  logic                       cap_en,
    input  logic                       clr_ovf,
    output logic                       rd_valid,
    output logic [TS_W+DATA_W-1:0]     rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_W + DATA_W;

    typedef enum logic {IDLE, TRACK} state_e;

    state_e            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;
    logic [RW-1:0]     mem_q [DEPTH];

    logic attempt, full, pop, push, drop;

    always_comb begin
        state_d = state_q;
        attempt = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_en) begin
                    attempt = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!cap_en) begin
                    state_d = IDLE;
                end else begin
`ifdef CPU_CAPTURE_ALL_EN
                    attempt = 1'b1;
`else
                    attempt = (cpu_data != last_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop at the same edge frees the slot, so a full FIFO can still accept a push.
    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && rd_ready;
    assign push = attempt && (!full || pop);
    assign drop = attempt && full && !pop;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        last_d     = attempt ? cpu_data : last_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: storage is not reset; emptying the pointers/count flushes it and rd_data is masked when empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {ts_q, cpu_data};
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
